// File: rtl/rbm_pkg.sv
// Shared types and helpers for the RBM hidden-unit sampler.
// Holds the probability width default, LFSR mask/step function and FSM states.
package rbm_pkg;

    localparam int          P_W_DEF   = 16;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic {
        FILL,
        DONE
    } hs_st_t;

    // Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
        logic [31:0] sh;
        sh = s >> 1;
        return s[0] ? (sh ^ LFSR_MASK) : sh;
    endfunction

endpackage

// File: rtl/rbm_lfsr32.sv
// 32-bit Galois LFSR that advances only when step is high.
// Ports: clk, rst (sync, active-high), step, state[31:0].
module rbm_lfsr32
    import rbm_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr32_next(state);
        end
    end

endmodule

// File: rtl/rbm_hidden_sampler.sv
// Bernoulli sampler and frame buffer for RBM hidden units.
// Ports: clk, rst, clear, in_valid/in_ready/in_p, rd_addr/rd_p/rd_h,
// frame_done, h_count. Macro HSAMP_STATS_EN builds the h=1 counter.
module rbm_hidden_sampler
    import rbm_pkg::*;
#(
    parameter int          H_DIM     = 64,
    parameter int          P_W       = P_W_DEF,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    localparam int         AW        = $clog2(H_DIM),
    localparam int         CW        = $clog2(H_DIM + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [P_W-1:0] in_p,
    input  logic [AW-1:0] rd_addr,
    output logic [P_W-1:0] rd_p,
    output logic          rd_h,
    output logic          frame_done,
    output logic [CW-1:0] h_count
);

    hs_st_t         st;
    hs_st_t         st_nxt;
    logic           accept;
    logic           last;
    logic [AW-1:0]  j;
    logic [31:0]    lfsr;
    logic [P_W-1:0] rnd;
    logic           h_new;
    logic           in_range;

    logic [P_W-1:0] mem_p [H_DIM];
    logic           mem_h [H_DIM];

    rbm_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (accept),
        .state (lfsr)
    );

    assign rnd   = P_W'(lfsr[15:0]);
    assign h_new = in_p > rnd;
    assign last  = (j == AW'(H_DIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= FILL;
        end else begin
            st <= st_nxt;
        end
    end

    // clear overrides everything and blocks the beat on the same cycle.
    always_comb begin
        st_nxt   = st;
        in_ready = 1'b0;
        accept   = 1'b0;
        if (clear) begin
            st_nxt = FILL;
        end else begin
            unique case (st)
                FILL: begin
                    in_ready = 1'b1;
                    accept   = in_valid;
                    if (in_valid && last) begin
                        st_nxt = DONE;
                    end
                end
                DONE: begin
                    st_nxt = DONE;
                end
                default: begin
                    st_nxt = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            j          <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            j <= last ? '0 : j + 1'b1;
            if (last) begin
                frame_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_p[j] <= in_p;
            mem_h[j] <= h_new;
        end
    end

    assign in_range = ({1'b0, rd_addr} < (AW + 1)'(H_DIM));

    // Same-cycle write is not forwarded: the read sees the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p <= '0;
            rd_h <= 1'b0;
        end else if (in_range) begin
            rd_p <= mem_p[rd_addr];
            rd_h <= mem_h[rd_addr];
        end else begin
            rd_p <= '0;
            rd_h <= 1'b0;
        end
    end

`ifdef HSAMP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            h_count <= '0;
        end else if (accept && h_new) begin
            h_count <= h_count + 1'b1;
        end
    end
`else
    assign h_count = '0;
`endif

endmodule

// File: tb/tb_rbm_hidden_sampler.sv
// Directed-vector bench for rbm_hidden_sampler with a reference
// LFSR/buffer model; H_DIM = 64.
module tb_rbm_hidden_sampler;

    localparam int H = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_p;
    logic [5:0]  rd_addr;
    logic [15:0] rd_p;
    logic        rd_h;
    logic        frame_done;
    logic [6:0]  h_count;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_lfsr;
    logic [15:0] m_p [H];
    logic        m_h [H];
    int          m_j;
    logic        m_done;
    int          m_cnt;

    rbm_hidden_sampler #(
        .H_DIM     (H),
        .P_W       (16),
        .LFSR_SEED (32'hACE1_2468)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p       (in_p),
        .rd_addr    (rd_addr),
        .rd_p       (rd_p),
        .rd_h       (rd_h),
        .frame_done (frame_done),
        .h_count    (h_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic int exp_cnt();
`ifdef HSAMP_STATS_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_j    = 0;
        m_done = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_lfsr = 32'hACE1_2468;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear();
        chk("clr_done", frame_done, 0);
        chk("clr_cnt", h_count, 0);
    endtask

    task automatic push(input logic [15:0] p);
        logic h;
        in_valid = 1'b1;
        in_p     = p;
        #1;
        chk("ready", in_ready, !m_done);
        tick();
        in_valid = 1'b0;
        if (!m_done) begin
            h         = p > m_lfsr[15:0];
            m_p[m_j]  = p;
            m_h[m_j]  = h;
            m_lfsr    = ref_step(m_lfsr);
            if (h) m_cnt++;
            if (m_j == H - 1) begin
                m_done = 1'b1;
                m_j    = 0;
            end else begin
                m_j++;
            end
        end
        chk("done", frame_done, m_done);
        chk("hcnt", h_count, exp_cnt());
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < H; a++) begin
            rd_addr = 6'(a);
            tick();
            chk(tag, {rd_p, rd_h}, {m_p[a], m_h[a]});
        end
    endtask

    initial begin
        rst      = 1'b1;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_p     = '0;
        rd_addr  = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_done", frame_done, 0);
        chk("rst_rdp", rd_p, 0);
        chk("rst_rdh", rd_h, 0);
        chk("rst_cnt", h_count, 0);
        chk("rst_rdy", in_ready, 1);

        // 1: zero probabilities
        for (int i = 0; i < H; i++) push(16'h0000);
        chk("t1_done", frame_done, 1);
        push(16'hFFFF);
        sweep("t1_rd");

        // 2: saturated probabilities
        do_clear();
        for (int i = 0; i < H; i++) push(16'hFFFF);
        chk("t2_cnt", h_count, exp_cnt());
        sweep("t2_rd");

        // 3: ramp with idle gaps
        do_clear();
        for (int i = 0; i < H; i++) begin
            push(16'(i * 1024));
            repeat (i % 3) tick();
        end
        sweep("t3_rd");

        // 4: clear colliding with beat 10
        do_clear();
        for (int i = 0; i < 10; i++) push(16'(i * 977 + 3));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_p     = 16'h1234;
        #1;
        chk("t4_rdy", in_ready, 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk("t4_done", frame_done, 0);
        chk("t4_cnt", h_count, 0);
        push(16'h8000);
        rd_addr = 6'd0;
        tick();
        chk("t4_a0", {rd_p, rd_h}, {m_p[0], m_h[0]});
        for (int i = 1; i < H; i++) push(16'(i * 1031));
        sweep("t4_rd");

        // 5: gaps, read-during-write, p==rand edges
        do_clear();
        for (int i = 0; i < H; i++) begin
            logic [15:0] p;
            logic [16:0] old;
            unique case (i % 3)
                0:       p = m_lfsr[15:0];
                1:       p = m_lfsr[15:0] + 16'd1;
                default: p = 16'($urandom);
            endcase
            rd_addr = 6'(m_j);
            old     = {m_p[m_j], m_h[m_j]};
            push(p);
            chk("t5_old", {rd_p, rd_h}, old);
            tick();
            chk("t5_new", {rd_p, rd_h}, {m_p[i], m_h[i]});
            repeat ($urandom_range(0, 2)) tick();
        end
        sweep("t5_rd");

        // 6: reset mid-frame
        do_clear();
        for (int i = 0; i < 30; i++) push(16'(i * 1024 + 7));
        rd_addr = 6'd5;
        tick();
        chk("t6_pre", rd_p, m_p[5]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("t6_rdp", rd_p, 0);
        chk("t6_rdh", rd_h, 0);
        chk("t6_done", frame_done, 0);
        chk("t6_cnt", h_count, 0);
        chk("t6_rdy", in_ready, 1);
        for (int i = 0; i < H; i++) push(16'(i * 1024));
        sweep("t6_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
